lut_neuron_array: RTL and testbench
===================================

Name: lut_neuron_array

Overview:
- Parametrised, runtime-loadable successor to the fixed per-neuron truth-table ROMs emitted for each layer.
- Holds N_NEURONS independent truth tables in distributed RAM, indexed by each neuron's concatenated quantised inputs.
- Adds a valid/ready inference pipeline with backpressure, plus a configuration port that reloads tables in-system without regenerating RTL.
- Sits between quantised activation layers; one instance per layer slice.

Parameters:
N_NEURONS, 4, number of neurons (tables) in the array
FAN_IN, 4, inputs per neuron
IN_BITS, 2, bits per input; ADDR_W = FAN_IN*IN_BITS (default 8, i.e. 256 entries)
OUT_BITS, 2, bits per neuron output
PIPE_STAGES, 1, inference latency in cycles; legal values 1 or 2
INIT_VAL, 0, OUT_BITS-wide value written to every entry by the post-reset clear

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
in_valid  in  1  inference input valid
in_ready  out  1  inference input accepted when in_valid&&in_ready
in_data  in  N_NEURONS*ADDR_W  neuron n address = in_data[n*ADDR_W +: ADDR_W]; input i of a neuron = bits [i*IN_BITS +: IN_BITS] of that address
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  N_NEURONS*OUT_BITS  neuron n result at [n*OUT_BITS +: OUT_BITS]
cfg_valid  in  1  configuration write request
cfg_ready  out  1  configuration write accepted
cfg_neuron  in  max(1,$clog2(N_NEURONS))  target table
cfg_addr  in  ADDR_W  table entry
cfg_data  in  OUT_BITS  entry value
cfg_last  in  1  marks the final write of a load burst
busy  out  1  high in CLEAR, DRAIN, LOAD

Behaviour:
- Reset:
  - state=CLEAR, clear counter=0.
  - All pipeline valid bits=0.
  - Outputs: out_valid=0, out_data=0, in_ready=0, cfg_ready=0, busy=1.
  - Reset mid-burst or mid-inference discards everything in flight and restarts CLEAR.
- CLEAR:
  - Each cycle writes INIT_VAL to entry [counter] of all tables; counter increments.
  - After entry 2^ADDR_W-1 is written, go to RUN. Duration is exactly 2^ADDR_W cycles.
  - cfg_valid is ignored (cfg_ready=0).
- RUN:
  - in_ready = !cfg_valid && (stage0 empty || stage0 advancing).
  - A transfer reads all N tables combinationally at their addresses and registers the results into stage0.
  - PIPE_STAGES=1: stage0 drives out_data/out_valid; latency is 1 cycle from the accepting edge.
  - PIPE_STAGES=2: adds a second register stage; latency is 2 cycles.
  - Each stage loads when it is empty or its downstream takes its data. Holding out_ready=0 freezes out_data stable with out_valid=1; no data loss or duplication. Full throughput is 1 result per cycle.
  - cfg_valid=1 takes priority over in_valid: the input is refused that cycle, and the state goes to DRAIN next cycle.
- DRAIN:
  - in_ready=0; the pipeline continues to empty via out_ready.
  - When all stage valid bits are 0, go to LOAD.
- LOAD:
  - cfg_ready=1; each cycle with cfg_valid writes cfg_data to table[cfg_neuron][cfg_addr].
  - A cfg_neuron value >= N_NEURONS is accepted and dropped (no write).
  - A write with cfg_last=1 returns the state to RUN next cycle.
  - A read after the load sees the new contents; write-before-read ordering is guaranteed by the drain.
- Writes to the same entry within a burst: the last write wins.
- Table storage carries rom_style/ram_style "distributed"; no reset on RAM contents other than the CLEAR sweep.

Decomposition:
- Shared package lut_neuron_pkg holds:
  - state enum {CLEAR, RUN, DRAIN, LOAD};
  - ADDR_W derivation function;
  - packing helper functions for neuron address and output slices.
- Natural sub-module: lut_table_ram, a single-table distributed RAM with 1 write port and 1 async read port, instantiated N_NEURONS times via generate.
- Top level holds the FSM, clear counter and pipeline/handshake logic.

Test Plan:
1. Reset, then wait: busy=1 and in_ready=0 for exactly 256 cycles (defaults). Then in_ready=1; inference on in_data=32'hFC_ED_00_13 gives out_data=8'h00 one cycle after acceptance.
2. Load burst with table0[8'hFC]=2'b00, table0[8'hEC]=2'b01 and cfg_last on the second write. Infer neuron0 addresses 8'hFC then 8'hEC → results 2'b00, 2'b01; other neurons return INIT_VAL.
3. Backpressure: out_ready=0 for 5 cycles with in_valid=1 streaming 3 distinct vectors. Neither PIPE_STAGES=1 nor PIPE_STAGES=2 drops or repeats a result; out_data is stable while stalled; order is preserved.
4. cfg_valid asserted while 2 results are in flight and out_ready=0. cfg_ready stays 0 until out_ready releases both results, then rises in the cycle after the pipeline empties; in_ready=0 throughout.
5. Simultaneous in_valid and cfg_valid in RUN: the input is not accepted; the FSM reaches LOAD. After cfg_last the input is accepted and uses the new table contents.
6. rst asserted mid-LOAD after 3 writes: out_valid=0 next cycle; the CLEAR sweep repeats; all loaded entries read back as INIT_VAL.

Source files
------------

// File: rtl/lut_neuron_pkg.sv
// Shared types and index helpers for the LUT neuron array.
package lut_neuron_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        DRAIN,
        LOAD
    } state_t;

    // Table address width: one neuron's concatenated quantised inputs.
    function automatic int unsigned addr_width(input int unsigned fan_in,
                                               input int unsigned in_bits);
        return fan_in * in_bits;
    endfunction

    // Width of the neuron selector; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB of neuron n's address within the packed input bus.
    function automatic int unsigned addr_lsb(input int unsigned neuron,
                                             input int unsigned addr_w);
        return neuron * addr_w;
    endfunction

    // LSB of neuron n's result within the packed output bus.
    function automatic int unsigned out_lsb(input int unsigned neuron,
                                            input int unsigned out_bits);
        return neuron * out_bits;
    endfunction

endpackage

// File: rtl/lut_neuron_array_if.sv
// Inference and configuration handshakes of one LUT neuron array.
interface lut_neuron_array_if
    import lut_neuron_pkg::*;
#(
    parameter int unsigned N_NEURONS = 4,
    parameter int unsigned FAN_IN    = 4,
    parameter int unsigned IN_BITS   = 2,
    parameter int unsigned OUT_BITS  = 2
);
    localparam int unsigned ADDR_W = addr_width(FAN_IN, IN_BITS);
    localparam int unsigned SEL_W  = sel_width(N_NEURONS);

    logic                          in_valid;
    logic                          in_ready;
    logic [N_NEURONS*ADDR_W-1:0]   in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [N_NEURONS*OUT_BITS-1:0] out_data;
    logic                          cfg_valid;
    logic                          cfg_ready;
    logic [SEL_W-1:0]              cfg_neuron;
    logic [ADDR_W-1:0]             cfg_addr;
    logic [OUT_BITS-1:0]           cfg_data;
    logic                          cfg_last;

    modport master (
        output in_valid, in_data, out_ready,
               cfg_valid, cfg_neuron, cfg_addr, cfg_data, cfg_last,
        input  in_ready, out_valid, out_data, cfg_ready
    );

    modport slave (
        input  in_valid, in_data, out_ready,
               cfg_valid, cfg_neuron, cfg_addr, cfg_data, cfg_last,
        output in_ready, out_valid, out_data, cfg_ready
    );

endinterface

// File: rtl/lut_table_ram.sv
// Single neuron truth table: one synchronous write port, one async read port.
module lut_table_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Contents are only ever initialised by the owner's clear sweep.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_array.sv
// Runtime-loadable array of neuron truth tables with a valid/ready pipeline.
module lut_neuron_array
    import lut_neuron_pkg::*;
#(
    parameter int unsigned         N_NEURONS   = 4,
    parameter int unsigned         FAN_IN      = 4,
    parameter int unsigned         IN_BITS     = 2,
    parameter int unsigned         OUT_BITS    = 2,
    parameter int unsigned         PIPE_STAGES = 1,   // 1 or 2
    parameter logic [OUT_BITS-1:0] INIT_VAL    = '0
) (
    input  logic               clk,
    input  logic               rst,
    lut_neuron_array_if.slave  bus,
    output logic               busy
);
    localparam int unsigned ADDR_W = addr_width(FAN_IN, IN_BITS);
    localparam int unsigned SEL_W  = sel_width(N_NEURONS);

    state_t                        state, state_nxt;
    logic [ADDR_W-1:0]             clr_cnt;
    logic [ADDR_W-1:0]             waddr;
    logic [OUT_BITS-1:0]           wdata;
    logic                          wr_cfg;
    logic [OUT_BITS-1:0]           rd [N_NEURONS];
    logic [N_NEURONS*OUT_BITS-1:0] rd_bus, s0_data, s1_data;
    logic                          s0_valid, s1_valid;
    logic                          s0_take, s0_load, s1_take, accept, pipe_empty;

    // Shared write port: the clear sweep, or an accepted load beat.
    assign waddr  = (state == CLEAR) ? clr_cnt : bus.cfg_addr;
    assign wdata  = (state == CLEAR) ? INIT_VAL : bus.cfg_data;
    assign wr_cfg = (state == LOAD) && bus.cfg_valid;

    // Selectors beyond the last neuron match no table, so the beat is dropped.
    for (genvar n = 0; n < N_NEURONS; n++) begin : g_tbl
        logic we;
        assign we = (state == CLEAR) || (wr_cfg && (bus.cfg_neuron == SEL_W'(n)));

        lut_table_ram #(
            .ADDR_W (ADDR_W),
            .DATA_W (OUT_BITS)
        ) u_ram (
            .clk   (clk),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (bus.in_data[addr_lsb(n, ADDR_W) +: ADDR_W]),
            .rdata (rd[n])
        );
    end

    // Pack per-neuron lookups into the result word.
    always_comb begin
        rd_bus = '0;
        for (int unsigned n = 0; n < N_NEURONS; n++)
            rd_bus[out_lsb(n, OUT_BITS) +: OUT_BITS] = rd[n];
    end

    assign s1_take    = !s1_valid || bus.out_ready;
    assign s0_take    = (PIPE_STAGES == 2) ? s1_take : bus.out_ready;
    assign s0_load    = !s0_valid || s0_take;
    assign accept     = bus.in_valid && bus.in_ready;
    assign pipe_empty = !s0_valid && !s1_valid;

    assign bus.in_ready  = (state == RUN) && !bus.cfg_valid && s0_load;
    assign bus.out_valid = (PIPE_STAGES == 2) ? s1_valid : s0_valid;
    assign bus.out_data  = (PIPE_STAGES == 2) ? s1_data : s0_data;
    assign bus.cfg_ready = (state == LOAD);
    assign busy          = (state != RUN);

    // State register and clear-sweep counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Next-state: config requests pre-empt inference and wait for an empty pipe.
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_cnt == '1) state_nxt = RUN;
            RUN:     if (bus.cfg_valid) state_nxt = DRAIN;
            DRAIN:   if (pipe_empty) state_nxt = LOAD;
            LOAD:    if (bus.cfg_valid && bus.cfg_last) state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    // Result pipeline; each stage loads when empty or when downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_data  <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            if (s0_load) s0_valid <= accept;
            if (accept) s0_data <= rd_bus;
            if (PIPE_STAGES == 2 && s1_take) begin
                s1_valid <= s0_valid;
                if (s0_valid) s1_data <= s0_data;
            end
        end
    end

endmodule

// File: tb/tb_lut_neuron_array.sv
// Directed bench: one array per pipeline depth, sharing config traffic.
module tb_lut_neuron_array;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy1, busy2;

    int total = 0;
    int bad   = 0;

    lut_neuron_array_if #(.N_NEURONS(4), .FAN_IN(4), .IN_BITS(2), .OUT_BITS(2)) bus1 ();
    lut_neuron_array_if #(.N_NEURONS(4), .FAN_IN(4), .IN_BITS(2), .OUT_BITS(2)) bus2 ();

    lut_neuron_array #(.PIPE_STAGES(1)) u_dut1 (
        .clk (clk), .rst (rst), .bus (bus1), .busy (busy1)
    );
    lut_neuron_array #(.PIPE_STAGES(2)) u_dut2 (
        .clk (clk), .rst (rst), .bus (bus2), .busy (busy2)
    );

    always #5 clk = ~clk;

    // Both arrays see identical table loads.
    assign bus2.cfg_valid  = bus1.cfg_valid;
    assign bus2.cfg_neuron = bus1.cfg_neuron;
    assign bus2.cfg_addr   = bus1.cfg_addr;
    assign bus2.cfg_data   = bus1.cfg_data;
    assign bus2.cfg_last   = bus1.cfg_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one vector to array 1 or 2 and return just after it is accepted.
    task automatic send(input int unsigned which, input logic [31:0] d);
        int unsigned n = 0;
        if (which == 1) begin bus1.in_valid = 1'b1; bus1.in_data = d; end
        else begin bus2.in_valid = 1'b1; bus2.in_data = d; end
        @(negedge clk);
        while (!((which == 1) ? bus1.in_ready : bus2.in_ready) && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("send_wait", 32'(n < 100), 32'd1);
        step();
        if (which == 1) bus1.in_valid = 1'b0;
        else bus2.in_valid = 1'b0;
    endtask

    // One configuration beat, accepted by array 1.
    task automatic cfg_write(input logic [1:0] nrn, input logic [7:0] a,
                             input logic [1:0] d, input logic l);
        int unsigned n = 0;
        bus1.cfg_valid = 1'b1; bus1.cfg_neuron = nrn;
        bus1.cfg_addr = a; bus1.cfg_data = d; bus1.cfg_last = l;
        @(negedge clk);
        while (!bus1.cfg_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("cfg_wait", 32'(n < 100), 32'd1);
        step();
        bus1.cfg_valid = 1'b0;
        bus1.cfg_last  = 1'b0;
    endtask

    // Called right after the last reset edge; counts busy cycles before RUN.
    task automatic measure_clear(input string tag);
        int unsigned n = 0;
        rst = 1'b0;
        while (busy1 && !bus1.in_ready && n < 400) begin
            n++;
            step();
        end
        chk(tag, n, 32'd256);
        chk("run_ready", 32'(bus1.in_ready), 32'd1);
    endtask

    // Output monitors: collect delivered results and check stall stability.
    logic       stall1 = 1'b0, stall2 = 1'b0;
    logic [7:0] hold1 = '0, hold2 = '0;
    logic [7:0] q1[$], q2[$];

    always @(negedge clk) begin
        if (stall1 && !rst) chk("hold1", 32'({bus1.out_valid, bus1.out_data}), 32'({1'b1, hold1}));
        if (stall2 && !rst) chk("hold2", 32'({bus2.out_valid, bus2.out_data}), 32'({1'b1, hold2}));
        stall1 <= bus1.out_valid && !bus1.out_ready;
        stall2 <= bus2.out_valid && !bus2.out_ready;
        hold1  <= bus1.out_data;
        hold2  <= bus2.out_data;
        if (bus1.out_valid && bus1.out_ready && !rst) q1.push_back(bus1.out_data);
        if (bus2.out_valid && bus2.out_ready && !rst) q2.push_back(bus2.out_data);
    end

    logic [31:0] vec  [3] = '{32'h0000_01EC, 32'h0000_0101, 32'h0000_01FC};
    logic [7:0]  vexp [3] = '{8'h0D, 8'h0E, 8'h0C};

    initial begin
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
        bus1.cfg_valid = 1'b0; bus1.cfg_neuron = '0; bus1.cfg_addr = '0;
        bus1.cfg_data = '0; bus1.cfg_last = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b1;

        // Reset state and clear sweep length
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus1.out_data), 32'd0);
        chk("rst_in_ready", 32'(bus1.in_ready), 32'd0);
        chk("rst_cfg_ready", 32'(bus1.cfg_ready), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd1);
        measure_clear("clear_len");
        send(1, 32'hFC_ED_00_13);
        chk("t1_valid", 32'(bus1.out_valid), 32'd1);
        chk("t1_data", 32'(bus1.out_data), 32'h00);

        // Load burst, then read back
        cfg_write(2'd0, 8'hFC, 2'b00, 1'b0);
        cfg_write(2'd0, 8'hEC, 2'b01, 1'b1);
        chk("t2_busy", 32'(busy1), 32'd0);
        send(1, 32'h0000_00FC);
        chk("t2_fc", 32'(bus1.out_data), 32'h00);
        send(1, 32'h1234_56EC);
        chk("t2_ec_valid", 32'(bus1.out_valid), 32'd1);
        chk("t2_ec", 32'(bus1.out_data), 32'h01);

        // Simultaneous input and config: input waits for the new table
        step();
        q1.delete();
        bus1.in_valid = 1'b1; bus1.in_data = 32'h0000_0101;
        bus1.cfg_valid = 1'b1; bus1.cfg_neuron = 2'd0;
        bus1.cfg_addr = 8'h01; bus1.cfg_data = 2'b10; bus1.cfg_last = 1'b0;
        #1;
        chk("t5_in_ready", 32'(bus1.in_ready), 32'd0);
        cfg_write(2'd0, 8'h01, 2'b10, 1'b0);
        cfg_write(2'd1, 8'h01, 2'b11, 1'b1);
        @(negedge clk);
        chk("t5_ready_after", 32'(bus1.in_ready), 32'd1);
        step();
        bus1.in_valid = 1'b0;
        chk("t5_valid", 32'(bus1.out_valid), 32'd1);
        chk("t5_data", 32'(bus1.out_data), 32'h0E);
        step();
        chk("t5_count", 32'(q1.size()), 32'd1);
        chk("t5_first", 32'((q1.size() > 0) ? q1[0] : 8'hFF), 32'h0E);

        // Backpressure on both pipeline depths
        q1.delete();
        q2.delete();
        bus1.out_ready = 1'b0;
        bus2.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) send(1, vec[i]);
            end
            begin
                for (int j = 0; j < 3; j++) send(2, vec[j]);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                bus1.out_ready = 1'b1;
                bus2.out_ready = 1'b1;
            end
        join
        repeat (6) step();
        chk("t3_cnt1", 32'(q1.size()), 32'd3);
        chk("t3_cnt2", 32'(q2.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk("t3_p1", 32'((k < q1.size()) ? q1[k] : 8'hFF), 32'(vexp[k]));
            chk("t3_p2", 32'((k < q2.size()) ? q2[k] : 8'hFF), 32'(vexp[k]));
        end

        // Config request with two results stalled in the 2-stage array
        q2.delete();
        bus2.out_ready = 1'b0;
        send(2, vec[0]);
        send(2, vec[1]);
        bus1.cfg_valid = 1'b1; bus1.cfg_neuron = 2'd3;
        bus1.cfg_addr = 8'h00; bus1.cfg_data = 2'b11; bus1.cfg_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_cfg_stall", 32'(bus2.cfg_ready), 32'd0);
            chk("t4_in_stall", 32'(bus2.in_ready), 32'd0);
        end
        step();
        bus2.out_ready = 1'b1;
        for (int m = 0; m < 3; m++) begin
            @(negedge clk);
            chk("t4_cfg_drain", 32'(bus2.cfg_ready), 32'd0);
            chk("t4_in_drain", 32'(bus2.in_ready), 32'd0);
        end
        @(negedge clk);
        chk("t4_cfg_rise", 32'(bus2.cfg_ready), 32'd1);
        chk("t4_in_load", 32'(bus2.in_ready), 32'd0);
        step();
        bus1.cfg_valid = 1'b0;
        bus1.cfg_last  = 1'b0;
        chk("t4_cnt", 32'(q2.size()), 32'd2);
        chk("t4_r0", 32'((q2.size() > 0) ? q2[0] : 8'hFF), 32'h0D);
        chk("t4_r1", 32'((q2.size() > 1) ? q2[1] : 8'hFF), 32'h0E);

        // Reset in the middle of a load burst
        cfg_write(2'd0, 8'h55, 2'b11, 1'b0);
        cfg_write(2'd1, 8'hAA, 2'b10, 1'b0);
        cfg_write(2'd2, 8'h33, 2'b01, 1'b0);
        rst = 1'b1;
        step();
        chk("t6_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("t6_busy", 32'(busy1), 32'd1);
        chk("t6_cfg_ready", 32'(bus1.cfg_ready), 32'd0);
        measure_clear("t6_clear_len");
        send(1, 32'h0033_AA55);
        chk("t6_loaded", 32'(bus1.out_data), 32'h00);
        send(1, 32'h0000_01EC);
        chk("t6_old", 32'(bus1.out_data), 32'h00);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
